// File: rtl/mem_rr_arbiter_if.sv
// Requester/RAM bus bundle for mem_rr_arbiter: packed per-requester request and
// response lanes plus the single-port RAM access signals.
interface mem_rr_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
);
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int MEM_AW = $clog2(MEM_DEPTH);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*BE_W-1:0]       req_be;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic                          rsp_err;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          mem_ready;
    logic                          mem_en;
    logic                          mem_we;
    logic [BE_W-1:0]               mem_be;
    logic [MEM_AW-1:0]             mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    // Arbiter side
    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Requesters and RAM side
    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters,
// with alignment/range checking and a one-cycle response pipeline.
module mem_rr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    mem_rr_arbiter_if.slave  bus
);
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);

    logic [BE_W-1:0]       be_arr    [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic [PTR_W-1:0] ptr_reg;
    logic             rsp_pend_reg;
    logic [PTR_W-1:0] rsp_id_reg;
    logic             rsp_is_err_reg;
    logic             rsp_is_load_reg;

    logic                  grant_any;
    logic [PTR_W-1:0]      grant_id;
    logic                  win_we;
    logic [BE_W-1:0]       win_be;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_legal;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign be_arr[gi]    = bus.req_be[gi*BE_W +: BE_W];
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign bus.rsp_valid[gi] = !rst && rsp_pend_reg && (rsp_id_reg == PTR_W'(gi));
        end
    endgenerate

    // Scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        int               sum;
        logic [PTR_W-1:0] cand;
        grant_any = 1'b0;
        grant_id  = '0;
        sum       = 0;
        cand      = '0;
        if (!rst && bus.mem_ready) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                sum = int'(ptr_reg) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                cand = PTR_W'(sum);
                if (bus.req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant_any) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    assign win_we    = bus.req_we[grant_id];
    assign win_be    = be_arr[grant_id];
    assign win_addr  = addr_arr[grant_id];
    assign win_wdata = wdata_arr[grant_id];
    assign win_legal = (win_addr[1:0] == 2'b00)
                    && ({1'b0, win_addr} < ADDR_LIMIT)
                    && !(win_we && (win_be == '0));

    // Illegal accesses are accepted and answered but never reach the RAM.
    assign bus.mem_en    = grant_any && win_legal;
    assign bus.mem_we    = bus.mem_en && win_we;
    assign bus.mem_be    = (bus.mem_en && win_we) ? win_be : '0;
    assign bus.mem_addr  = bus.mem_en ? win_addr[MEM_AW+1:2] : '0;
    assign bus.mem_wdata = bus.mem_en ? win_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg         <= '0;
            rsp_pend_reg    <= 1'b0;
            rsp_id_reg      <= '0;
            rsp_is_err_reg  <= 1'b0;
            rsp_is_load_reg <= 1'b0;
        end else begin
            rsp_pend_reg <= grant_any;
            if (grant_any) begin
                rsp_id_reg      <= grant_id;
                rsp_is_err_reg  <= !win_legal;
                rsp_is_load_reg <= !win_we;
                ptr_reg         <= (grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id + PTR_W'(1);
            end
        end
    end

    assign bus.rsp_err   = !rst && rsp_pend_reg && rsp_is_err_reg;
    assign bus.rsp_rdata = (!rst && rsp_pend_reg && !rsp_is_err_reg && rsp_is_load_reg)
                         ? bus.mem_rdata : '0;

endmodule
